multi_seq: RTL and testbench
============================

MULTI_SEQ -- requirements
Module: multi_seq

Interface
REQ-001 SHALL provide parameter RADIX, default 54: operand width in bits.
REQ-002 SHALL provide parameter A_W, default 27: A-limb width, matching the DSP A port.
REQ-003 SHALL provide parameter B_W, default 18: B-limb width, matching the DSP B port.
REQ-004 SHALL derive localparams NA = ceil(RADIX/A_W), NB = ceil(RADIX/B_W), N = NA*NB, PW = A_W+B_W.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1: operands a/b valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept operands.
REQ-009 SHALL have port a, input, RADIX: multiplicand.
REQ-010 SHALL have port b, input, RADIX: multiplier.
REQ-011 SHALL have port out_valid, output, 1: res valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts res.
REQ-013 SHALL have port res, output, 2*RADIX: full product a*b.

Function
REQ-014 SHALL implement states IDLE, MUL, DRAIN, DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE, combinationally from state.
REQ-016 SHALL, in IDLE, register a and b zero-padded to NA*A_W and NB*B_W bits, clear the accumulator and k, and go to MUL on in_valid&&in_ready.
REQ-017 SHALL, in MUL, issue one limb pair per cycle in order k = i*NB+j (i: A-limb 0..NA-1 outer, j: B-limb 0..NB-1 inner), k incrementing 0..N-1.
REQ-018 SHALL use exactly one unsigned A_W x B_W multiplier with a registered PW-bit product, one cycle latency.
REQ-019 SHALL add each registered product, shifted left by i*A_W + j*B_W, into a 2*RADIX-bit accumulator one cycle after the product register, discarding bits above 2*RADIX-1.
REQ-020 SHALL go from MUL to DRAIN after issuing k = N-1, and from DRAIN to DONE after the last product has been accumulated.
REQ-021 SHALL assert out_valid on the edge N+2 cycles after the accepting edge (8 cycles at default parameters).
REQ-022 SHALL, in DONE, hold out_valid=1 and res stable until out_valid&&out_ready, then return to IDLE on that edge.
REQ-023 SHALL ignore in_valid, a and b outside IDLE; operands captured at acceptance SHALL be used even if the inputs change.
REQ-024 SHALL handle RADIX not a multiple of A_W or B_W through the zero padding, producing the exact product.
REQ-025 SHALL hold res at its last value outside DONE; res is meaningful only while out_valid=1.

Reset
REQ-026 SHALL, with rst_n low at any time (including mid-MUL or DONE), asynchronously force state=IDLE, k=0, out_valid=0, res=0, accumulator=0, product register=0.
REQ-027 SHALL drive in_ready=1 during and after reset.
REQ-028 SHALL require no synchronous init; the first accept SHALL be possible on the first clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with MULTI_PARTIAL_OUT_EN defined, add outputs pp_valid (1), pp_idx ($clog2(N)) and pp_data (PW), registered with the product, so each partial product is streamed once per k with pp_valid=1; pp_valid SHALL reset to 0.
REQ-030 SHALL, without MULTI_PARTIAL_OUT_EN, omit these ports and their logic entirely, leaving all other behaviour identical.

Verification
REQ-031 SHALL cover: defaults, a=b=2^54-1, out_ready=1 -> out_valid 8 cycles after accept, res = 2^108 - 2^55 + 1, back in IDLE one cycle later.
REQ-032 SHALL cover: a=3, b=5, out_ready held 0 for 5 cycles after out_valid -> res=15 held stable, in_ready=0 throughout, accept on the cycle out_ready rises.
REQ-033 SHALL cover: rst_n pulsed low at k=3 -> out_valid=0, res=0, in_ready=1 at once; next operands a=7, b=9 -> res=63.
REQ-034 SHALL cover: RADIX=40 (NA=2, NB=3), a=2^40-1, b=1 -> res=2^40-1 after 8 cycles.
REQ-035 SHALL cover: in_valid held high with a/b changing during MUL -> the result equals the product of the operands captured at acceptance only.
REQ-036 SHALL cover: MULTI_PARTIAL_OUT_EN defined, a=2^27, b=2^18 -> exactly one nonzero pp_data=1 at pp_idx=4 (i=1, j=1), six pp_valid pulses.

Source files
------------

// File: rtl/multi_seq.sv
// Sequential RADIX x RADIX multiplier built from one A_W x B_W DSP-style multiplier, one limb pair per cycle.
// Optional partial-product stream ports: define MULTI_PARTIAL_OUT_EN.
module multi_seq #(
  parameter int unsigned RADIX = 54,
  parameter int unsigned A_W   = 27,
  parameter int unsigned B_W   = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RADIX-1:0]     a,
  input  logic [RADIX-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*RADIX-1:0]   res
`ifdef MULTI_PARTIAL_OUT_EN
  ,
  output logic                 pp_valid,
  output logic [((((RADIX+A_W-1)/A_W)*((RADIX+B_W-1)/B_W)) > 1 ?
                $clog2(((RADIX+A_W-1)/A_W)*((RADIX+B_W-1)/B_W)) : 1)-1:0] pp_idx,
  output logic [A_W+B_W-1:0]   pp_data
`endif
);

  localparam int unsigned NA = (RADIX + A_W - 1) / A_W;
  localparam int unsigned NB = (RADIX + B_W - 1) / B_W;
  localparam int unsigned N  = NA * NB;
  localparam int unsigned PW = A_W + B_W;
  localparam int unsigned RW = 2 * RADIX;
  localparam int unsigned AP = NA * A_W;
  localparam int unsigned BP = NB * B_W;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IW = (NA > 1) ? $clog2(NA) : 1;
  localparam int unsigned JW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MUL   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state, state_n;
  logic [AP-1:0] a_q;
  logic [BP-1:0] b_q;
  logic [KW-1:0] k;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [PW-1:0] prod, prod_n;
  logic [IW-1:0] pi;
  logic [JW-1:0] pj;
  logic          pv;
  logic [RW-1:0] acc, acc_add;
  logic [A_W-1:0] limb_a;
  logic [B_W-1:0] limb_b;
  int unsigned   sh;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state: DRAIN waits until the product register holds nothing unaccumulated.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)               state_n = MUL;
      MUL:     if (k == KW'(N - 1))        state_n = DRAIN;
      DRAIN:   if (!pv)                    state_n = DONE;
      DONE:    if (out_valid && out_ready) state_n = IDLE;
      default:                             state_n = IDLE;
    endcase
  end

  always_comb begin
    limb_a  = a_q[i*A_W +: A_W];
    limb_b  = b_q[j*B_W +: B_W];
    prod_n  = PW'(limb_a) * PW'(limb_b);
    sh      = 32'(pi) * A_W + 32'(pj) * B_W;
    acc_add = RW'(prod) << sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      k         <= '0;
      i         <= '0;
      j         <= '0;
      prod      <= '0;
      pi        <= '0;
      pj        <= '0;
      pv        <= 1'b0;
      acc       <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      pv <= (state == MUL);
      if (pv) acc <= acc + acc_add;
      case (state)
        IDLE: if (in_valid) begin
          a_q <= AP'(a);
          b_q <= BP'(b);
          acc <= '0;
          k   <= '0;
          i   <= '0;
          j   <= '0;
        end
        MUL: begin
          prod <= prod_n;
          pi   <= i;
          pj   <= j;
          k    <= k + KW'(1);
          if (j == JW'(NB - 1)) begin
            j <= '0;
            i <= i + IW'(1);
          end else begin
            j <= j + JW'(1);
          end
        end
        DRAIN: if (!pv) begin
          res       <= acc;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MULTI_PARTIAL_OUT_EN
  logic [KW-1:0] pk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pk <= '0;
    else if (state == MUL) pk <= k;
  end

  assign pp_valid = pv;
  assign pp_idx   = pk;
  assign pp_data  = prod;
`endif

endmodule

// File: tb/tb_multi_seq.sv
// Scoreboard bench for multi_seq: accepted operands feed a queue of exact products checked at the output handshake.
module tb_multi_seq;

  localparam int unsigned R  = 54;
  localparam int unsigned RW = 2 * R;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, out_valid;
  logic          out_ready = 1'b1;
  logic [R-1:0]  a, b;
  logic [RW-1:0] res;

  logic          in_valid2, in_ready2, out_valid2;
  logic          out_ready2 = 1'b1;
  logic [39:0]   a2, b2;
  logic [79:0]   res2;

`ifdef MULTI_PARTIAL_OUT_EN
  logic        pp_valid, pp_valid2;
  logic [2:0]  pp_idx, pp_idx2;
  logic [44:0] pp_data, pp_data2;
`endif

  multi_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .res(res)
`ifdef MULTI_PARTIAL_OUT_EN
    , .pp_valid(pp_valid), .pp_idx(pp_idx), .pp_data(pp_data)
`endif
  );

  multi_seq #(.RADIX(40)) dut40 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2), .res(res2)
`ifdef MULTI_PARTIAL_OUT_EN
    , .pp_valid(pp_valid2), .pp_idx(pp_idx2), .pp_data(pp_data2)
`endif
  );

  int total = 0, bad = 0, cyc = 0;
  logic [RW-1:0] exp_q[$];
  int lat_q[$];
  bit rand_rdy = 1'b0, force_rdy = 1'b1, prev_ov = 1'b0, hs_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the exact product of whatever operands the handshake accepted.
  always @(posedge clk)
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(RW'(a) * RW'(b));
      lat_q.push_back(cyc + 9);
    end

  // Monitor: choose out_ready for the coming edge, then check what that edge will see.
  always @(negedge clk) begin
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    if (rst_n) begin
      if (hs_prev) check("idle_after_done", 128'(in_ready), 128'(1));
      hs_prev = 1'b0;
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) fail_now("latency_no_accept");
        else check("latency", 128'(cyc), 128'(lat_q.pop_front()));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_out_valid");
        else if (out_ready) begin
          check("res", 128'(res), 128'(exp_q.pop_front()));
          hs_prev = 1'b1;
        end else begin
          check("res_held", 128'(res), 128'(exp_q[0]));
          check("in_ready_busy", 128'(in_ready), 128'(0));
        end
      end
    end
    prev_ov = out_valid;
  end

`ifdef MULTI_PARTIAL_OUT_EN
  int pp_cnt = 0, pp_nz = 0;
  logic [2:0]  pp_last_idx = '0;
  logic [44:0] pp_last_dat = '0;
  always @(negedge clk)
    if (rst_n && pp_valid) begin
      pp_cnt++;
      if (pp_data != 0) begin
        pp_nz++;
        pp_last_idx = pp_idx;
        pp_last_dat = pp_data;
      end
    end
`endif

  task automatic send(input logic [R-1:0] va, input logic [R-1:0] vb);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) fail_now("send_timeout");
    in_valid = 1'b1;
    a = va;
    b = vb;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || out_valid) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  function automatic logic [R-1:0] rnd54();
    return R'({$urandom(), $urandom()});
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_res", 128'(res), 128'(0));
    repeat (2) @(negedge clk);

    // First accept on the very first edge after reset release, all-ones operands.
    rst_n = 1'b1; in_valid = 1'b1; a = '1; b = '1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("first_edge_accept", 128'(in_ready), 128'(0));
    wait_drain();

    // Consumer stalls for 5 cycles; result must hold.
    force_rdy = 1'b0;
    send(R'(3), R'(5));
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) fail_now("stall_timeout");
    repeat (5) @(negedge clk);
    force_rdy = 1'b1;
    send(R'(11), R'(13));
    wait_drain();

    // Asynchronous reset mid-multiply.
    send(R'(100), R'(200));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_res", 128'(res), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(R'(7), R'(9));
    wait_drain();

    // in_valid held high while operands churn every cycle.
    @(negedge clk);
    in_valid = 1'b1;
    repeat (40) begin
      a = rnd54();
      b = rnd54();
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_drain();

    // Random operands with random back-pressure.
    rand_rdy = 1'b1;
    repeat (25) send(rnd54(), rnd54());
    wait_drain();
    rand_rdy = 1'b0;
    force_rdy = 1'b1;

`ifdef MULTI_PARTIAL_OUT_EN
    @(posedge clk);
    #1 pp_cnt = 0; pp_nz = 0;
    send(R'(1) << 27, R'(1) << 18);
    wait_drain();
    check("pp_pulses", 128'(pp_cnt), 128'(6));
    check("pp_nonzero", 128'(pp_nz), 128'(1));
    check("pp_idx", 128'(pp_last_idx), 128'(4));
    check("pp_data", 128'(pp_last_dat), 128'(1));
`endif

    // RADIX=40 instance: padding of partial limbs.
    @(negedge clk);
    in_valid2 = 1'b1; a2 = '1; b2 = 40'd1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 30) begin @(posedge clk); #1 n++; end
    check("r40_latency", 128'(n), 128'(8));
    check("r40_res", 128'(res2), 128'(80'hFF_FFFF_FFFF));
    check("r40_in_ready", 128'(in_ready2), 128'(0));
    repeat (2) @(negedge clk);
    check("r40_idle", 128'(in_ready2), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
